// File: rtl/fifo_stream_reader.sv
// Drain-side FIFO adapter: issues reads against a 1-cycle-latency FIFO port and
// replays the returned words through a 3-entry skid buffer. Optional out_last: FIFO_READER_LAST_EN.
module fifo_stream_reader #(
  parameter int WIDTH   = 32,
  parameter int PKT_LEN = 16
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dataout,
  output logic             fifo_read,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_READER_LAST_EN
  ,
  output logic             out_last
`endif
);

  // Stream handshake: a word transfers on every rising edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready, and once raised
  // it stays up with out_data stable until that transfer happens.

  logic [1:0]       count;
  logic [1:0]       wp;
  logic [1:0]       rp;
  logic             inflight;
  logic [WIDTH-1:0] buf_q [3];
  logic [2:0]       occupancy;
  logic             capture;
  logic             pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words held plus the one on its way back; a read is only issued if it fits.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign fifo_read = reset && !fifo_empty && (occupancy <= 3'd2);
  assign capture   = inflight;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data = buf_q[0];
    case (rp)
      2'd1:    out_data = buf_q[1];
      2'd2:    out_data = buf_q[2];
      default: out_data = buf_q[0];
    endcase
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      count    <= 2'd0;
      wp       <= 2'd0;
      rp       <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      inflight <= fifo_read;
      if (capture) begin
        for (int i = 0; i < 3; i++)
          if (wp == 2'(i)) buf_q[i] <= fifo_dataout;
        wp <= next_ptr(wp);
      end
      if (pop) rp <= next_ptr(rp);
      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_READER_LAST_EN
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

  logic [PW-1:0] pkt_cnt;

  always_ff @(posedge ck) begin
    if (!reset) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      pkt_cnt <= (pkt_cnt == PKT_MAX) ? '0 : pkt_cnt + 1'b1;
    end
  end

  assign out_last = out_valid && (pkt_cnt == PKT_MAX);
`else
  // PKT_LEN must be >= 1; it shapes nothing when out_last is not built.
  if (PKT_LEN < 1) begin : g_pkt_len_invalid
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural 1-cycle-latency FIFO, directed phases,
// scoreboard on every transfer. Define FIFO_READER_LAST_EN to also check out_last.
module tb_fifo_stream_reader;

  localparam int WIDTH = 32;

  logic             ck;
  logic             reset;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dataout;
  logic             fifo_read;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef FIFO_READER_LAST_EN
  logic             out_last;
`endif

  fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(4)) dut (
    .ck           (ck),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_dataout (fifo_dataout),
    .fifo_read    (fifo_read),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef FIFO_READER_LAST_EN
    ,
    .out_last     (out_last)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // ---------------- behavioural FIFO ----------------
  logic [WIDTH-1:0] mem [0:2047];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             flush  = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge ck) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_read) begin
      fifo_dataout <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               n_vec   = 0;
  int               n_err   = 0;
  int               pop_cnt = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got %0h expected no word (t=%0t)", out_data, $time);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
      pop_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b1;
    tick();
    reset = 1'b1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] d0;
  int               pushed;
  int               target;
  int               cyc;

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    // Reset with a non-empty FIFO: no reads, outputs zero.
    for (int i = 0; i < 3; i++) begin
      mem[wr_ptr] = 32'hdead_0000 + 32'(i);
      wr_ptr++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge ck);
      check("rst_read", {31'd0, fifo_read}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", out_data, 32'd0);
    end
    tick();
    do_reset();

    // First-word latency, then 64 words back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_word(32'(i));
    @(negedge ck);
    check("lat_read", {31'd0, fifo_read}, 32'd1);
    tick();
    @(negedge ck);
    check("lat_valid_n", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge ck);
    check("lat_valid_n1", {31'd0, out_valid}, 32'd1);
    check("lat_data", out_data, 32'd0);
    for (int i = 1; i < 64; i++) begin
      tick();
      @(negedge ck);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    tick();
    @(negedge ck);
    check("stream_end_valid", {31'd0, out_valid}, 32'd0);
    check("stream_end_read", {31'd0, fifo_read}, 32'd0);
    check("stream_count", 32'(pop_cnt), 32'd64);

    // Backpressure for 5 cycles mid-stream.
    tick();
    for (int i = 0; i < 20; i++) push_word(32'h1000 + 32'(i));
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    d0 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      if (i == 0) d0 = out_data;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold", out_data, d0);
      if (i >= 1) check("bp_read", {31'd0, fifo_read}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge ck);
    check("bp_rel_read", {31'd0, fifo_read}, 32'd0);
    tick();
    @(negedge ck);
    check("bp_resume", {31'd0, fifo_read}, 32'd1);
    check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
    tick();
    @(negedge ck);
    check("bp_drain_valid2", {31'd0, out_valid}, 32'd1);
    tick();
    wait_drain(100);

    // Random stalls and random producer writes, 1000 words.
    pushed = 0;
    target = pop_cnt + 1000;
    cyc    = 0;
    while (pop_cnt < target && cyc < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push_word($urandom);
        pushed++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    check("rand_words", 32'(pop_cnt), 32'(target));
    out_ready = 1'b1;
    wait_drain(50);

    // Reset while count = 2 with a word in flight.
    for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    flush = 1'b1;
    @(negedge ck);
    check("mid_rst_read", {31'd0, fifo_read}, 32'd0);
    @(posedge ck);
    @(negedge ck);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    tick();
    reset = 1'b1;
    flush = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
    cyc = 0;
    @(negedge ck);
    while (!out_valid && cyc < 20) begin
      @(negedge ck);
      cyc++;
    end
    check("restart_first", out_data, 32'h200);
    tick();
    wait_drain(50);

`ifdef FIFO_READER_LAST_EN
    // out_last every 4th word, held through a stall on word 7.
    begin
      int k;
      int stall_cnt;
      do_reset();
      k = 0;
      stall_cnt = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) push_word(32'h300 + 32'(i));
      cyc = 0;
      while (k < 12 && cyc < 200) begin
        @(negedge ck);
        if (out_valid && out_ready) begin
          check("last_flag", {31'd0, out_last}, {31'd0, (k % 4) == 3});
          k++;
        end else if (out_valid && k == 7) begin
          check("last_hold", {31'd0, out_last}, 32'd1);
          stall_cnt++;
        end
        tick();
        out_ready = !(k == 7 && stall_cnt < 3);
        cyc++;
      end
      check("last_words", 32'(k), 32'd12);
      check("last_stalls", 32'(stall_cnt), 32'd3);
      out_ready = 1'b1;
      wait_drain(50);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
